// File: rtl/dps_enc_24_seq_pkg.sv
// Shared constants for the 24-wire DPS (Fibonacci numeral system) encoder.
// Holds the Fibonacci weights FNS01..FNS24 (FNS01=1, FNS02=2, FNSk=FNSk-1+FNSk-2),
// the binary data width, the largest encodable value, the weight-select function
// and the FSM state encodings.
// Optional feature macro used by the encoder: DPS_ENC_SELFCHECK_EN.
package dps_enc_24_seq_pkg;

    localparam int unsigned CODE_W     = 24;
    localparam int unsigned DATA_W     = 18;
    localparam int unsigned STEP_CNT_W = 5;
    // Remainder carries one spare MSB above the data word.
    localparam int unsigned REM_W      = DATA_W + 1;

    localparam int unsigned FNS01 = 1;
    localparam int unsigned FNS02 = 2;
    localparam int unsigned FNS03 = 3;
    localparam int unsigned FNS04 = 5;
    localparam int unsigned FNS05 = 8;
    localparam int unsigned FNS06 = 13;
    localparam int unsigned FNS07 = 21;
    localparam int unsigned FNS08 = 34;
    localparam int unsigned FNS09 = 55;
    localparam int unsigned FNS10 = 89;
    localparam int unsigned FNS11 = 144;
    localparam int unsigned FNS12 = 233;
    localparam int unsigned FNS13 = 377;
    localparam int unsigned FNS14 = 610;
    localparam int unsigned FNS15 = 987;
    localparam int unsigned FNS16 = 1597;
    localparam int unsigned FNS17 = 2584;
    localparam int unsigned FNS18 = 4181;
    localparam int unsigned FNS19 = 6765;
    localparam int unsigned FNS20 = 10946;
    localparam int unsigned FNS21 = 17711;
    localparam int unsigned FNS22 = 28657;
    localparam int unsigned FNS23 = 46368;
    localparam int unsigned FNS24 = 75025;

    // Greedy-maximal codeword: bits 23, 22 and the alternating bits 20, 18, .., 0
    // (code 24'hD55555) -> 75025 + 92736 + 28656.
    localparam logic [DATA_W-1:0] DPS_MAX24 = 18'd196417;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StConv = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    // Weight of codeword bit idx; bit 22 carries twice FNS23.
    function automatic logic [REM_W-1:0] dps_w24(input logic [STEP_CNT_W-1:0] idx);
        logic [REM_W-1:0] w;
        case (idx)
            5'd0:    w = REM_W'(FNS01);
            5'd1:    w = REM_W'(FNS02);
            5'd2:    w = REM_W'(FNS03);
            5'd3:    w = REM_W'(FNS04);
            5'd4:    w = REM_W'(FNS05);
            5'd5:    w = REM_W'(FNS06);
            5'd6:    w = REM_W'(FNS07);
            5'd7:    w = REM_W'(FNS08);
            5'd8:    w = REM_W'(FNS09);
            5'd9:    w = REM_W'(FNS10);
            5'd10:   w = REM_W'(FNS11);
            5'd11:   w = REM_W'(FNS12);
            5'd12:   w = REM_W'(FNS13);
            5'd13:   w = REM_W'(FNS14);
            5'd14:   w = REM_W'(FNS15);
            5'd15:   w = REM_W'(FNS16);
            5'd16:   w = REM_W'(FNS17);
            5'd17:   w = REM_W'(FNS18);
            5'd18:   w = REM_W'(FNS19);
            5'd19:   w = REM_W'(FNS20);
            5'd20:   w = REM_W'(FNS21);
            5'd21:   w = REM_W'(FNS22);
            5'd22:   w = REM_W'(2 * FNS23);
            5'd23:   w = REM_W'(FNS24);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dps_enc_24_seq_weight_rom.sv
// dps_weight_rom_24: combinational bit-index -> DPS weight lookup.
// Ports:
//   idx_i     bit index 0..23 (other values return 0)
//   weight_o  weight of that codeword bit, REM_W bits wide
module dps_weight_rom_24
    import dps_enc_24_seq_pkg::*;
(
    input  logic [STEP_CNT_W-1:0] idx_i,
    output logic [REM_W-1:0]      weight_o
);

    always_comb begin
        weight_o = dps_w24(idx_i);
    end

endmodule

// File: rtl/dps_enc_24_seq.sv
// dps_enc_24_seq: sequential 24-wire DPS crosstalk-avoidance encoder.
// Greedy compare-and-subtract, MSB weight first, one codeword bit per clock.
// A word accepted on edge E0 yields code_valid_o after edge E24.
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   din_valid_i   data word offered
//   din_ready_o   encoder idle and able to accept
//   din_i         binary value to encode
//   code_valid_o  codeword held for downstream
//   code_ready_i  downstream accepts the codeword
//   code_o        DPS codeword
//   busy_o        conversion in progress
//   err_o         codeword invalid (input above DPS_MAX24, or self-check failure)
// Optional feature macro: DPS_ENC_SELFCHECK_EN adds a final-remainder and
// adjacent-ones check to err_o on entry to HOLD.
module dps_enc_24_seq
    import dps_enc_24_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    input  logic [DATA_W-1:0] din_i,
    output logic              code_valid_o,
    input  logic              code_ready_i,
    output logic [CODE_W-1:0] code_o,
    output logic              busy_o,
    output logic              err_o
);

    logic [1:0]            state_q, state_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [STEP_CNT_W-1:0] idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic                  err_q, err_d;
    logic [REM_W-1:0]      weight;
    logic                  take;

    dps_weight_rom_24 u_rom (
        .idx_i    (idx_q),
        .weight_o (weight)
    );

    assign take = (rem_q >= weight);

`ifdef DPS_ENC_SELFCHECK_EN
    logic rem_zero_q, rem_zero_d;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        code_d  = code_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        err_d   = err_q;
`ifdef DPS_ENC_SELFCHECK_EN
        rem_zero_d = rem_zero_q;
`endif
        case (state_q)
            StIdle: begin
                if (din_valid_i) begin
                    rem_d   = {1'b0, din_i};
                    code_d  = '0;
                    idx_d   = STEP_CNT_W'(CODE_W - 1);
                    oor_d   = (din_i > DPS_MAX24);
                    err_d   = 1'b0;
                    state_d = StConv;
`ifdef DPS_ENC_SELFCHECK_EN
                    rem_zero_d = 1'b1;
`endif
                end
            end
            StConv: begin
                code_d[idx_q] = take;
                if (take) begin
                    rem_d = rem_q - weight;
                end
                if (idx_q == '0) begin
                    state_d = StHold;
                    err_d   = oor_q;
`ifdef DPS_ENC_SELFCHECK_EN
                    // Check the raw greedy result before any out-of-range zeroing.
                    err_d      = oor_q | (|(code_d[CODE_W-3:0] & code_d[CODE_W-2:1]));
                    rem_zero_d = (rem_d == '0);
`endif
                    if (oor_q) begin
                        code_d = '0;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StHold: begin
                if (code_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rem_q   <= '0;
            code_q  <= '0;
            idx_q   <= STEP_CNT_W'(CODE_W - 1);
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
        end
    end

`ifdef DPS_ENC_SELFCHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_zero_q <= 1'b1;
        end else begin
            rem_zero_q <= rem_zero_d;
        end
    end

    assign err_o = err_q | (code_valid_o & ~rem_zero_q);
`else
    assign err_o = err_q;
`endif

    assign din_ready_o  = (state_q == StIdle);
    assign code_valid_o = (state_q == StHold);
    assign busy_o       = (state_q == StConv);
    assign code_o       = code_q;

endmodule

// File: doc/dps_enc_24_seq.md
Name: dps_enc_24_seq

Overview:
- Sequential 24-bit DPS (Fibonacci-numeral-system) crosstalk-avoidance encoder.
- Converts a binary data word into the 24-wire codeword that the combinational DPS 24-bit decoder maps back to the same value.
- Uses greedy compare-and-subtract, MSB weight first, one codeword bit per clock.
- Sits on the transmit side of the bus, with valid/ready handshakes on both sides.

Parameters:
- CODE_W, 24, codeword width; fixed, because the weight table has exactly 24 entries.
- DATA_W, `DBLEN24, binary data width (from FNS.vh).
- STEP_CNT_W, 5, width of the bit-index counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din_valid  in  1  data word offered.
- din_ready  out  1  encoder can accept a word.
- din  in  DATA_W  binary value to encode.
- code_valid  out  1  codeword available.
- code_ready  in  1  downstream accepts the codeword.
- code  out  CODE_W  DPS codeword.
- busy  out  1  conversion in progress (state CONV).
- err  out  1  qualifies code; high when the input was out of range (plus self-check failures if enabled).

Behaviour:
- Weight table W[i], i = 23..0:
  - W[23] = `FNS24
  - W[22] = 2*`FNS23
  - W[i] = `FNS(i+1) for i <= 21
- Reset values: state IDLE; din_ready=1; code_valid=0; code=0; busy=0; err=0; remainder=0; bit index=23.
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - din_ready=1.
  - On din_valid&&din_ready: latch din into remainder (DATA_W+1 bits, MSB zero), clear the code shift register, set index=23, compute the range flag (din > `DPSMAX24), go to CONV.
- CONV:
  - One bit per cycle for index 23 down to 0.
  - If remainder >= W[index]: code[index]=1 and remainder -= W[index]; else code[index]=0.
  - After index 0 is processed, go to HOLD.
  - Compare is unsigned and full width; no truncation of the weights.
- HOLD:
  - code_valid=1 and code is stable.
  - On code_ready, go to IDLE; din_ready is high from the next cycle.
  - code and err hold their values until the next accept.
- Latency: the input handshake occurs on edge E0; code_valid is high after edge E24 (24 clocks). With code_ready held high, a new word is accepted every 26 cycles.
- No input/output overlap: din_ready=0 in CONV and HOLD.
- Out-of-range input (din > `DPSMAX24):
  - Conversion still runs for 24 cycles so timing is unchanged.
  - code is forced to 24'h000000 and err=1 in HOLD.
- Boundaries:
  - din=0 yields all-zero code.
  - din=`DPSMAX24 yields the largest valid codeword, with remainder reaching 0.
  - Simultaneous din_valid during HOLD is ignored (din_ready=0).
  - rst in any state returns to IDLE within one edge and discards the partial code; code_valid drops on that edge.

Optional Feature:
- Macro: DPS_ENC_SELFCHECK_EN.
- Defined: on entry to HOLD, err is additionally set if either
  - the final remainder != 0, or
  - any adjacent pair code[i]&code[i+1] is set (forbidden pattern) for i = 0..21.
  The self-check uses one extra register for the remainder-zero flag, with no added latency.
- Undefined: err reflects only the range check; the extra logic is absent.

Decomposition:
- Shared FNS.vh holds:
  - `FNS01..`FNS24, `DBLEN24
  - new `DPSMAX24 (sum of the greedy-maximal codeword weights)
  - new `DPS_W24(i) weight-select macro
  - FSM state localparam encodings
- Natural sub-module: dps_weight_rom_24, a combinational index -> W[index] lookup. Everything else stays in the top module.

Test Plan:
- din=0 with code_ready=1 -> code_valid after exactly 24 clocks, code=24'h000000, err=0.
- din=`FNS05 -> code=24'h000010; din=`FNS24 -> code=24'h800000; din=`DPSMAX24 -> code decodes to `DPSMAX24 and err=0.
- Random in-range din (10k values) -> feeding code through the existing DPS 24-bit decoder returns din; no adjacent ones.
- din=`DPSMAX24+1 -> code=24'h000000, err=1, same 24-cycle latency.
- code_ready held low 10 cycles in HOLD -> code/err stable, din_ready=0; with din_valid high throughout, a word is accepted one cycle after code_ready.
- rst asserted at CONV cycle 12 -> next edge: IDLE, din_ready=1, code_valid=0, code=0; the following word encodes correctly.
